regfile_burst_reader: RTL and testbench
=======================================

Name: regfile_burst_reader

Overview:
- Bank of 2**ADDR_W word registers with a single write port, like the existing 32-bit register: data in, write enable, Clk.
- Adds the read side: a burst reader that streams consecutive registers out over a valid/ready handshake.
- Sits between register storage and any consumer that drains several words per request, e.g. a debug or bus-readout path.

Parameters:
- WIDTH, 32, data word width.
- ADDR_W, 3, address width; register count NREGS = 2**ADDR_W.
- LEN_W, ADDR_W+1, width of the burst-length field.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Wr  input  1  write enable.
- Wr_addr  input  ADDR_W  write address.
- Data_in  input  WIDTH  write data.
- Rd_start  input  1  burst request, sampled when idle.
- Rd_addr  input  ADDR_W  burst start address.
- Rd_len  input  LEN_W  burst word count, 1..NREGS.
- Out_ready  input  1  consumer accepts Data_out this cycle.
- Data_out  output  WIDTH  registered read word.
- Out_valid  output  1  Data_out holds a valid word.
- Out_last  output  1  current word is the final word of the burst.
- Busy  output  1  burst in progress.

Behaviour:
- Reset asserted (Reset=0):
  - All registers cleared to 0.
  - Data_out=0, Out_valid=0, Out_last=0, Busy=0.
  - FSM goes to IDLE; any burst in progress is aborted with no further words.
- Write port:
  - At each edge with Wr=1, reg[Wr_addr] <= Data_in.
  - Writes are independent of FSM state; a write during a burst is legal.
- FSM states: IDLE, STREAM.
- IDLE:
  - Busy=0, Out_valid=0.
  - At an edge with Rd_start=1 and Rd_len!=0:
    - Data_out <= reg[Rd_addr]; Out_valid <= 1; Busy <= 1.
    - Out_last <= (Rd_len==1).
    - Internal pointer <= Rd_addr+1; remaining <= Rd_len-1.
    - Go to STREAM.
  - Rd_start with Rd_len==0 is ignored.
  - Rd_len > NREGS is saturated to NREGS.
- Latency: first word is valid in the cycle after the Rd_start edge.
- STREAM:
  - Handshake: a transfer occurs at an edge with Out_valid=1 and Out_ready=1.
  - If Out_ready=0, Data_out, Out_valid and Out_last hold steady, with no bubbles and no drops.
  - On transfer with Out_last=0:
    - Data_out <= reg[pointer]; pointer++; remaining--.
    - Out_last <= (remaining==1).
  - On transfer with Out_last=1: Out_valid <= 0, Out_last <= 0, Busy <= 0; go to IDLE.
  - Throughput: one word per cycle while Out_ready=1.
  - Data_out is not cleared on burst end.
- Address wrap: pointer increments modulo NREGS (7 -> 0 for ADDR_W=3).
- Rd_start while Busy=1 is ignored; no queueing.
- A new burst may start at the first IDLE edge after Out_last is accepted. There is one idle cycle between bursts.
- Read/write collision: a write to the address being loaded into Data_out on the same edge makes Data_out take the OLD contents; the register itself takes the new value.
- A write to the address already latched in Data_out does not alter Data_out.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: on a read/write collision (same edge, same address), Data_out loads Data_in, i.e. write-through forwarding.
- Undefined: Data_out loads the old register contents, as specified above.

Decomposition:
- Shared package regfile_pkg:
  - FSM state typedef (IDLE, STREAM).
  - Default WIDTH and ADDR_W constants.
- One natural sub-module, regfile_storage: register array with write port and one combinational read port.
- regfile_burst_reader holds the FSM, pointer, counter and output register.

Test Plan:
- Reset, then fill: Reset low then high; write reg[i]=32'h1000_0000+i for i=0..7 -> Busy=0, Out_valid=0, Data_out=0 before any request.
- Basic burst: Rd_start, Rd_addr=2, Rd_len=3, Out_ready=1 -> valid the next cycle; words 0x10000002, 0x10000003, 0x10000004 on consecutive cycles; Out_last only with 0x10000004; Busy falls after the last transfer.
- Wrap and backpressure: Rd_addr=6, Rd_len=4, Out_ready toggling 1,0,0,1,... -> words 6,7,0,1 in order, each held stable while Out_ready=0, no duplicates.
- Collision: during a burst from addr 0, write Data_in=32'hDEAD_BEEF to addr 1 on the edge that loads word 1 -> without macro 0x10000001 is output; with REGFILE_BYPASS_EN 0xDEADBEEF is output; a later read of addr 1 returns 0xDEADBEEF in both builds.
- Ignored requests: Rd_len=0 -> Busy stays 0. Rd_start mid-burst with a different address -> current burst unchanged.
- Reset mid-burst: assert Reset during word 2 of an 8-word burst -> outputs go to 0 immediately (asynchronous), no further words; a subsequent read of any address returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the burst-reading register
//               bank (reader FSM state encoding, default word/address widths).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_burst_reader_if.sv
// ============================================================================
// Module      : regfile_burst_reader_if
// Description : Bundles the write port, burst request and valid/ready read
//               stream of the burst-reading register bank.
// Ports       : master - requester/consumer side (drives Wr*, Data_in,
//                        Rd_*, Out_ready; observes Data_out, Out_*, Busy)
//               slave  - register bank side (the reverse)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_burst_reader_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
);

  logic              Wr;
  logic [ADDR_W-1:0] Wr_addr;
  logic [WIDTH-1:0]  Data_in;
  logic              Rd_start;
  logic [ADDR_W-1:0] Rd_addr;
  logic [LEN_W-1:0]  Rd_len;
  logic              Out_ready;
  logic [WIDTH-1:0]  Data_out;
  logic              Out_valid;
  logic              Out_last;
  logic              Busy;

  modport master (
    output Wr, Wr_addr, Data_in, Rd_start, Rd_addr, Rd_len, Out_ready,
    input  Data_out, Out_valid, Out_last, Busy
  );

  modport slave (
    input  Wr, Wr_addr, Data_in, Rd_start, Rd_addr, Rd_len, Out_ready,
    output Data_out, Out_valid, Out_last, Busy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_storage.sv
// ============================================================================
// Module      : regfile_storage
// Description : 2**ADDR_W x WIDTH register array, one synchronous write port
//               and one combinational read port. Cleared by reset.
// Ports       : Clk, Reset (async, active-low)
//               i_wr, i_wr_addr, i_wr_data - write port
//               i_rd_addr, o_rd_data       - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_storage
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  wire logic              Clk,
  input  wire logic              Reset,
  input  wire logic              i_wr,
  input  wire logic [ADDR_W-1:0] i_wr_addr,
  input  wire logic [WIDTH-1:0]  i_wr_data,
  input  wire logic [ADDR_W-1:0] i_rd_addr,
  output      logic [WIDTH-1:0]  o_rd_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_regs [NREGS];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write is not visible here.
  assign o_rd_data = r_regs[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/regfile_burst_reader.sv
// ============================================================================
// Module      : regfile_burst_reader
// Description : Register bank with a burst reader that streams consecutive
//               registers (wrapping modulo 2**ADDR_W) over valid/ready.
//               Optional macro REGFILE_BYPASS_EN: a write colliding with the
//               word being loaded into Data_out is forwarded (write-through).
// Ports       : Clk, Reset (async, active-low)
//               bus (regfile_burst_reader_if.slave): Wr, Wr_addr, Data_in,
//               Rd_start, Rd_addr, Rd_len, Out_ready -> Data_out, Out_valid,
//               Out_last, Busy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_burst_reader
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input wire logic              Clk,
  input wire logic              Reset,
  regfile_burst_reader_if.slave bus
);

  localparam int               NREGS   = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] C_NREGS = LEN_W'(NREGS);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr,   w_ptr_nxt;
  logic [LEN_W-1:0]  r_rem,   w_rem_nxt;
  logic [WIDTH-1:0]  r_data,  w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_last,  w_last_nxt;
  logic              r_busy,  w_busy_nxt;

  logic [LEN_W-1:0]  w_len_sat;
  logic              w_start;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [WIDTH-1:0]  w_rd_data;
  logic [WIDTH-1:0]  w_load_data;

  assign w_len_sat = (bus.Rd_len > C_NREGS) ? C_NREGS : bus.Rd_len;
  assign w_start   = bus.Rd_start && (bus.Rd_len != '0);
  assign w_xfer    = r_valid && bus.Out_ready;
  // In IDLE the first word comes straight from the request address.
  assign w_rd_addr = (r_state == IDLE) ? bus.Rd_addr : r_ptr;

  regfile_storage #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_wr      (bus.Wr),
    .i_wr_addr (bus.Wr_addr),
    .i_wr_data (bus.Data_in),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

`ifdef REGFILE_BYPASS_EN
  assign w_load_data = (bus.Wr && (bus.Wr_addr == w_rd_addr)) ? bus.Data_in : w_rd_data;
`else
  assign w_load_data = w_rd_data;
`endif

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start)           w_state_nxt = STREAM;
      STREAM:  if (w_xfer && r_last)  w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic; everything holds unless a start or transfer occurs.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_data_nxt  = w_load_data;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_last_nxt  = (w_len_sat == LEN_W'(1));
          w_ptr_nxt   = bus.Rd_addr + ADDR_W'(1);
          w_rem_nxt   = w_len_sat - LEN_W'(1);
        end
      end
      STREAM: begin
        if (w_xfer) begin
          if (r_last) begin
            // Data_out deliberately keeps the final word.
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
          end else begin
            w_data_nxt = w_load_data;
            w_ptr_nxt  = r_ptr + ADDR_W'(1);
            w_rem_nxt  = r_rem - LEN_W'(1);
            w_last_nxt = (r_rem == LEN_W'(1));
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.Data_out  = r_data;
  assign bus.Out_valid = r_valid;
  assign bus.Out_last  = r_last;
  assign bus.Busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_burst_reader.sv
// ============================================================================
// Module      : tb_regfile_burst_reader
// Description : Self-checking bench for regfile_burst_reader. A register
//               image plus a queue of expected burst words serve as the
//               reference; honours REGFILE_BYPASS_EN for collision results.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_burst_reader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 4;
  localparam int NREGS  = 8;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  regfile_burst_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  regfile_burst_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mem [NREGS];
  logic [WIDTH-1:0] expq [$];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic write_reg(input int a, input logic [WIDTH-1:0] d);
    bus.Wr      = 1'b1;
    bus.Wr_addr = ADDR_W'(a);
    bus.Data_in = d;
    step();
    bus.Wr = 1'b0;
    mem[a] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ":valid"}, 32'(bus.Out_valid), 32'd0);
    chk({tag, ":busy"},  32'(bus.Busy),      32'd0);
    chk({tag, ":last"},  32'(bus.Out_last),  32'd0);
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = ready pattern 1,0,0,...
  // poke: issue a conflicting Rd_start mid-burst.
  // collide: write DEADBEEF to the address loaded on the first transfer edge.
  task automatic burst(input string tag, input int addr, input int len, input int mode,
                       input bit poke, input bit collide);
    int n;
    int cyc;
    bit rdy;
    n = (len > NREGS) ? NREGS : len;
    expq.delete();
    for (int k = 0; k < n; k++) expq.push_back(mem[(addr + k) % NREGS]);
    bus.Rd_start = 1'b1;
    bus.Rd_addr  = ADDR_W'(addr);
    bus.Rd_len   = LEN_W'(len);
    step();
    bus.Rd_start = 1'b0;
    cyc = 0;
    while (expq.size() > 0 && cyc < 64) begin
      chk({tag, ":valid"}, 32'(bus.Out_valid), 32'd1);
      chk({tag, ":busy"},  32'(bus.Busy),      32'd1);
      chk({tag, ":data"},  bus.Data_out,       expq[0]);
      chk({tag, ":last"},  32'(bus.Out_last),  32'(expq.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = ((cyc % 3) == 0);
      endcase
      bus.Out_ready = rdy;
      if (poke && cyc == 1) begin
        bus.Rd_start = 1'b1;
        bus.Rd_addr  = ADDR_W'(addr + 3);
        bus.Rd_len   = LEN_W'(2);
      end
      if (collide && cyc == 0) begin
        bus.Wr      = 1'b1;
        bus.Wr_addr = ADDR_W'(addr + 1);
        bus.Data_in = 32'hDEAD_BEEF;
        mem[(addr + 1) % NREGS] = 32'hDEAD_BEEF;
`ifdef REGFILE_BYPASS_EN
        if (expq.size() > 1) expq[1] = 32'hDEAD_BEEF;
`endif
      end
      step();
      bus.Rd_start = 1'b0;
      bus.Wr       = 1'b0;
      if (rdy) void'(expq.pop_front());
      cyc++;
    end
    chk({tag, ":timeout"}, 32'(expq.size()), 32'd0);
    chk_idle({tag, ":end"});
    bus.Out_ready = 1'b0;
  endtask

  initial begin
    bus.Wr        = 1'b0;
    bus.Wr_addr   = '0;
    bus.Data_in   = '0;
    bus.Rd_start  = 1'b0;
    bus.Rd_addr   = '0;
    bus.Rd_len    = '0;
    bus.Out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) mem[i] = '0;

    // Reset, then fill.
    step();
    step();
    chk_idle("rst");
    chk("rst:data", bus.Data_out, 32'd0);
    Reset = 1'b1;
    step();
    for (int i = 0; i < NREGS; i++) write_reg(i, 32'h1000_0000 + i);
    chk_idle("fill");
    chk("fill:data", bus.Data_out, 32'd0);

    // Directed bursts.
    burst("basic", 2, 3, 0, 1'b0, 1'b0);
    chk("basic:hold", bus.Data_out, 32'h1000_0004);
    burst("wrap",  6, 4, 2, 1'b0, 1'b0);
    burst("coll",  0, 3, 0, 1'b0, 1'b1);
    burst("rdbk",  1, 1, 0, 1'b0, 1'b0);
    burst("len0",  3, 0, 0, 1'b0, 1'b0);
    burst("poke",  0, 8, 1, 1'b1, 1'b0);
    burst("sat",   4, 12, 1, 1'b0, 1'b0);
    burst("one",   7, 1, 2, 1'b0, 1'b0);

    // Randomized writes and bursts.
    for (int t = 0; t < 20; t++) begin
      write_reg(int'($urandom_range(0, NREGS - 1)), $urandom);
      burst("rand", int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset mid-burst during word 2 of an 8-word burst.
    bus.Out_ready = 1'b1;
    bus.Rd_start  = 1'b1;
    bus.Rd_addr   = '0;
    bus.Rd_len    = LEN_W'(8);
    step();
    bus.Rd_start = 1'b0;
    chk("mrst:w0", bus.Data_out, mem[0]);
    step();
    chk("mrst:w1", bus.Data_out, mem[1]);
    step();
    chk("mrst:w2", bus.Data_out, mem[2]);
    Reset = 1'b0;
    #1;
    chk("mrst:data", bus.Data_out, 32'd0);
    chk_idle("mrst");
    for (int i = 0; i < NREGS; i++) mem[i] = '0;
    @(negedge Clk);
    Reset = 1'b1;
    step();
    chk_idle("mrst:after");
    burst("zero", 5, 2, 0, 1'b0, 1'b0);
    burst("zero2", int'($urandom_range(0, NREGS - 1)), 8, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
